// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, and
// buffers the returned word for decode behind a valid/ready handshake.
module pc_fetch_unit #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_kill;

  logic            w_redirect;
  logic            w_misaligned;
  logic            w_fire;
  logic [XLEN-1:0] w_target;

  assign w_redirect     = branch_taken | jump;
  assign w_target       = jump ? jump_target : branch_target;
  assign w_misaligned   = |w_target[1:0];
  assign w_fire         = if_valid & if_ready & ~stall;
  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_addr      = r_pc;

  // NOTE: sequential state is written with <= so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_kill        <= 1'b0;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_pc_plus4   <= '0;
      if_instr      <= '0;
      fetch_fault   <= 1'b0;
    end else if (r_state != ST_FAULT) begin
      if (w_redirect) begin
        // A redirect always discards the buffered instruction; the kill flag
        // only survives when the accepted request's response is still due.
        r_pc     <= w_target;
        if_valid <= 1'b0;
        r_kill   <= 1'b0;
        if (w_misaligned) begin
          r_state     <= ST_FAULT;
          fetch_fault <= 1'b1;
        end else begin
          case (r_state)
            ST_REQ: begin
              if (imem_req_ready) begin
                r_state <= ST_WAIT;
                r_kill  <= 1'b1;
              end else begin
                r_state <= ST_REQ;
              end
            end
            ST_WAIT: begin
              if (imem_rsp_valid) begin
                r_state <= ST_REQ;
              end else begin
                r_state <= ST_WAIT;
                r_kill  <= 1'b1;
              end
            end
            default: r_state <= ST_REQ;
          endcase
        end
      end else begin
        case (r_state)
          ST_REQ: begin
            if (imem_req_ready) begin
              r_inflight_pc <= r_pc;
              r_pc          <= r_pc + XLEN'(4);
              r_state       <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_kill) begin
                r_kill  <= 1'b0;
                r_state <= ST_REQ;
              end else begin
                if_instr    <= imem_rsp_data;
                if_pc       <= r_inflight_pc;
                if_pc_plus4 <= r_inflight_pc + XLEN'(4);
                if_valid    <= 1'b1;
                r_state     <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (w_fire) begin
              if_valid <= 1'b0;
              r_state  <= ST_REQ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: an instruction-memory model feeds the DUT
// and a scoreboard of expected hand-offs is compared at every decode fire.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        fetch_fault;

  int   n_checks;
  int   n_errors;
  int   n_fires;
  exp_t sb_q[$];

  logic        hold_rsp;
  int          rsp_delay;
  logic        pend;
  logic [31:0] paddr;
  int          cnt;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = mem_word(pc);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one response rsp_delay cycles after accept, held back while hold_rsp.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend           = 1'b0;
    paddr          = '0;
    cnt            = 0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        continue;
      end
      if (pend && !hold_rsp) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          pend           = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_aligned", 32'(imem_addr[1:0]), 32'd0);
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = rsp_delay - 1;
      end
    end
  end

  // Decode-side monitor: every fire must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && if_ready && !stall) begin
        n_fires++;
        check("sb_nonempty_at_fire", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("fire_pc", if_pc, e.pc);
          check("fire_pc_plus4", if_pc_plus4, e.pc4);
          check("fire_instr", if_instr, e.instr);
        end
      end
    end
  end

  task automatic clear_inputs();
    branch_taken   = 1'b0;
    branch_target  = '0;
    jump           = 1'b0;
    jump_target    = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
    hold_rsp       = 1'b0;
    rsp_delay      = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd0);
    check({tag, "_if_instr"}, if_instr, 32'd0);
    check({tag, "_fetch_fault"}, 32'(fetch_fault), 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, imem_addr, RESET_PC);
  endtask

  task automatic do_reset();
    // NOTE: bench inputs are driven with blocking assignments, away from the active edge.
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_if_valid_low", 32'(if_valid), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_req_valid", 32'(imem_req_valid), 32'd1);
    check("rel_req_addr", imem_addr, RESET_PC);
  endtask

  task automatic mid_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    hold_rsp = 1'b0;
    rst_n    = 1'b1;
    #1;
    check({tag, "_rel_req_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_rel_req_addr"}, imem_addr, RESET_PC);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !if_valid; i++) tick();
    check("wait_if_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic park();
    imem_req_ready = 1'b0;
    if_ready       = 1'b0;
  endtask

  task automatic redirect_jump(input logic [31:0] tgt);
    jump        = 1'b1;
    jump_target = tgt;
    tick();
    jump        = 1'b0;
  endtask

  initial begin
    int base;
    n_checks = 0;
    n_errors = 0;
    n_fires  = 0;
    rst_n    = 1'b1;
    clear_inputs();
    tick();

    // Sequential fetch from reset.
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_drain(60);
    park();

    // Branch while the 0x8 response is held back: that word must never be handed off.
    do_reset();
    push_exp(32'h0);
    push_exp(32'h4);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_drain(60);
    hold_rsp = 1'b1;
    tick();
    tick();
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken  = 1'b0;
    check("kill_if_valid", 32'(if_valid), 32'd0);
    check("kill_req_valid", 32'(imem_req_valid), 32'd0);
    push_exp(32'h100);
    hold_rsp = 1'b0;
    wait_drain(60);
    park();

    // Jump in the same cycle the request is accepted.
    do_reset();
    push_exp(32'h40);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_jump(32'h40);
    check("same_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    wait_drain(60);
    park();

    // Branch and jump together: jump target wins.
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    redirect_jump(32'h80);
    branch_taken  = 1'b0;
    check("both_req_valid", 32'(imem_req_valid), 32'd1);
    check("both_req_addr", imem_addr, 32'h80);
    push_exp(32'h80);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_drain(60);
    park();

    // Stall and backpressure in HOLD at 0x10.
    redirect_jump(32'h10);
    imem_req_ready = 1'b1;
    wait_valid(30);
    imem_req_ready = 1'b0;
    check("hold_pc", if_pc, 32'h10);
    stall    = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_instr", if_instr, mem_word(32'h10));
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    end
    stall    = 1'b0;
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_if_valid", 32'(if_valid), 32'd1);
      check("bp_if_pc", if_pc, 32'h10);
      check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    end
    base = n_fires;
    push_exp(32'h10);
    if_ready = 1'b1;
    wait_drain(20);
    repeat (5) tick();
    check("single_handoff", 32'(n_fires - base), 32'd1);
    check("after_fire_if_valid", 32'(if_valid), 32'd0);
    park();

    // Misaligned branch target with a stale request accepted in the same cycle.
    branch_taken   = 1'b1;
    branch_target  = 32'h102;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    tick();
    branch_taken = 1'b0;
    check("fault_set", 32'(fetch_fault), 32'd1);
    check("fault_if_valid", 32'(if_valid), 32'd0);
    check("fault_req_valid", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      jump        = i[0];
      jump_target = 32'h0;
      tick();
      check("fault_hold_req_valid", 32'(imem_req_valid), 32'd0);
      check("fault_hold_sticky", 32'(fetch_fault), 32'd1);
      check("fault_hold_if_valid", 32'(if_valid), 32'd0);
    end
    jump = 1'b0;
    park();

    // PC wraps from the top of the address space without faulting.
    do_reset();
    redirect_jump(32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    rsp_delay      = 2;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_drain(60);
    park();
    check("wrap_no_fault", 32'(fetch_fault), 32'd0);
    rsp_delay = 1;

    // Asynchronous reset while in WAIT, then while in HOLD.
    do_reset();
    hold_rsp       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("pre_rst_wait_req_valid", 32'(imem_req_valid), 32'd0);
    mid_reset("rst_wait");
    redirect_jump(32'h20);
    imem_req_ready = 1'b1;
    wait_valid(30);
    imem_req_ready = 1'b0;
    check("pre_rst_hold_pc", if_pc, 32'h20);
    mid_reset("rst_hold");
    push_exp(RESET_PC);
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    wait_drain(60);
    park();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core.
- Owns the program counter and issues one instruction-memory request at a time.
- Presents the fetched instruction and its PC to decode through a valid/ready handshake.
- Consumes the branch comparator's taken result, and the jump redirect, to steer the PC and to kill stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- branch_taken  input  1  taken result from the branch comparator (EX stage).
- branch_target  input  32  branch destination address.
- jump  input  1  JAL/JALR redirect request (EX stage).
- jump_target  input  32  jump destination address.
- stall  input  1  hazard-unit stall; blocks hand-off to decode.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address.
- imem_rsp_valid  input  1  instruction data returned.
- imem_rsp_data  input  32  instruction word.
- if_valid  output  1  fetched instruction available to decode.
- if_ready  input  1  decode can accept.
- if_pc  output  32  PC of if_instr.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.
- if_instr  output  32  instruction word.
- fetch_fault  output  1  sticky misaligned-target fault.

Behaviour:
- Reset is asynchronous, active-low, and may assert at any time, including mid-transaction.
  - pc=RESET_PC, state=REQ, kill=0.
  - if_valid=0, if_pc/if_instr/if_pc_plus4=0, fetch_fault=0.
  - imem_req_valid=1 combinationally in REQ, so the first request (addr=RESET_PC) is visible in the first cycle after release.
  - An in-flight response is simply dropped; no state survives reset.
- redirect = branch_taken | jump. Target = jump ? jump_target : branch_target (jump wins if both are asserted).
- fire = if_valid & if_ready & ~stall.
- States: REQ, WAIT, HOLD, FAULT.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready: latch inflight_pc=pc, set pc<=pc+4, go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=0: register if_instr=imem_rsp_data, if_pc=inflight_pc, if_pc_plus4=inflight_pc+4, set if_valid=1, go to HOLD.
  - On imem_rsp_valid with kill=1: discard the data, clear kill, go to REQ.
- HOLD:
  - if_valid=1; if_pc, if_instr and if_pc_plus4 stay stable until fire.
  - On fire: set if_valid=0, go to REQ.
- Latency: rsp_valid in cycle N gives if_valid=1 in cycle N+1. Only one request is ever outstanding.
- Redirect has priority over stall and over every normal transition. Redirect handling by state:
  - Any state: pc <= target, and if_valid is cleared next cycle (the buffered instruction is dropped with no fire).
  - REQ with no imem_req_ready: go to REQ, new address visible next cycle.
  - REQ with imem_req_ready in the same cycle: the accepted request is stale; go to WAIT with kill=1.
  - WAIT with no rsp_valid: stay in WAIT, set kill=1.
  - WAIT with rsp_valid in the same cycle: drop the response, go to REQ, kill=0.
  - HOLD: go to REQ.
- Misaligned redirect (target[1:0] != 0):
  - No fetch is issued to the bad address.
  - Next cycle: fetch_fault=1, state=FAULT, if_valid=0.
- FAULT:
  - imem_req_valid=0; all inputs are ignored until reset.
  - Any outstanding response is ignored.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no fault.
- stall never alters pc or the request side; it only blocks fire.

Test Plan:
- Reset/sequential fetch: RESET_PC=0, imem ready always, rsp 1 cycle after accept, if_ready=1 → if_pc sequence 0x0, 0x4, 0x8, each if_instr matches memory, and if_valid never asserts during reset.
- Branch kill in WAIT: hold the rsp for pc=0x8, pulse branch_taken with target 0x100 while in WAIT, then return rsp → the 0x8 word never appears on if_instr, next if_pc=0x100.
- Same-cycle redirect and handshakes:
  - jump=1 (target 0x40) in the same cycle as imem_req_ready → the response is discarded and the next if_pc=0x40.
  - branch_taken and jump both high → jump_target is used.
- Stall/backpressure: HOLD with if_pc=0x10, stall=1 for 5 cycles, then if_ready=0 for 3 cycles → if_valid and if_instr stay stable, no new imem_req_valid, and exactly one hand-off after release.
- Fault and wrap:
  - branch target 0x102 → fetch_fault=1, imem_req_valid=0 for 20 cycles.
  - Separately, sequential fetch at 0xFFFF_FFFC is followed by if_pc=0x0 with no fault.
- Reset mid-operation: assert rst_n=0 asynchronously while in WAIT and in HOLD → outputs clear immediately, and after release the first imem_addr=RESET_PC.
